spi_txn_scheduler: RTL
======================

// Module: spi_txn_scheduler
// PURPOSE
//  Shares the single SPI clock/slave-select generator between NUM_REQ requesters.
//  Arbitrates round-robin and latches the winner's SPI timing config and TX word.
//  Drives the generator's start/config inputs and tracks slave-select to report per-requester completion.
//  Sits between the acquisition/config engines and the sclk generator + shift register.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  DATA_SIZE      16    bits per SPI transaction
//  TIMEOUT_CYCLES 255   max sys clks from start assertion to slave-select falling
// PORTS
//  i_sys_clk      in   1              system clock; one clock domain
//  i_sys_rst      in   1              reset, asynchronous, active-high
//  i_req          in   NUM_REQ        level request per requester; held until o_gnt
//  i_req_data     in   NUM_REQ*DS     TX word per requester, slice k = [k*DS +: DS]
//  i_req_cfg      in   NUM_REQ*33     per req {cpol,tx2tx[7:0],hold[7:0],setup[7:0],clk_period[7:0]}
//  o_gnt          out  NUM_REQ        one-hot, 1-cycle pulse: request accepted, data latched
//  o_done         out  NUM_REQ        one-hot, 1-cycle pulse: transaction completed
//  o_err          out  NUM_REQ        one-hot, 1-cycle pulse: start timed out
//  o_busy         out  1              high from grant to done/err
//  o_spi_start    out  1              start request to generator
//  o_clk_period   out  8              latched config to generator (also setup/hold/tx2tx below)
//  o_setup_cycles out  8
//  o_hold_cycles  out  8
//  o_tx2tx_cycles out  8
//  o_cpol         out  1
//  o_tx_data      out  DATA_SIZE      latched TX word to shift register
//  i_ss_start     in   1              generator slave-select, active-low (1 = idle/tx2tx)
// BEHAVIOUR
//  Reset: o_gnt/o_done/o_err=0, o_busy=0, o_spi_start=0, cfg/tx outputs=0, o_cpol=0,
//   state=IDLE, rr pointer=NUM_REQ-1 (req 0 has first priority). Reset mid-txn aborts; no done/err.
//  FSM states: IDLE, START, ACTIVE.
//  IDLE: if any i_req -> pick first set bit at/after ptr+1 (wrap); same edge: o_gnt pulse,
//   latch cfg+data, ptr<=winner, o_busy<=1, o_spi_start<=1, tmo_cnt<=0, ->START.
//  START: o_spi_start held 1 (generator may still be in tx2tx wait, ss high).
//   i_ss_start==0 -> o_spi_start<=0, ->ACTIVE.
//   else tmo_cnt++; tmo_cnt==TIMEOUT_CYCLES-1 -> o_err[winner] pulse, o_spi_start<=0, o_busy<=0, ->IDLE.
//  ACTIVE: i_ss_start==1 (rising) -> o_done[winner] pulse, o_busy<=0, ->IDLE.
//  Latency: i_req high in IDLE -> o_gnt+o_spi_start next edge; done 1 clk after ss rises.
//  Config/tx outputs stable from grant until next grant; never change while o_busy.
//  New requests ignored while o_busy; requests stay pending (level). A requester dropping
//   i_req before grant is simply not served. Grant and done never in the same cycle.
//  Simultaneous requests: strict round-robin; winner becomes lowest priority next round.
//  clk_period/setup/hold/tx2tx passed unchecked; cfg value 0 is caller's error (may time out).
//  tmo_cnt is 8 bits; TIMEOUT_CYCLES must be 1..255.
// STRUCTURE
//  Package spi_sched_pkg: state localparams (one-hot, 3b), cfg field offsets/width (33),
//   CFG_PERIOD_LSB=0, SETUP=8, HOLD=16, TX2TX=24, CPOL=32.
//  Sub-module rr_arbiter #(N): i_req, i_ptr -> o_onehot, o_idx, o_any (combinational).
//  Top holds FSM, latches, timeout counter, pulse outputs.
// TESTING (bench models generator: ss falls 3 clks after start seen, rises after 20 clks)
//  Single req1, data 16'hA5C3, cfg period 8 -> o_gnt=4'b0010 next clk, o_tx_data=A5C3, o_done[1] once.
//  req 0,2,3 held together 6 txns -> grant order 0,2,3,0,2,3; no overlap of o_busy windows.
//  Back-to-back while model in tx2tx (ss high 10 clks) -> o_spi_start stays 1 until ss falls, no err.
//  Model never drops ss, TIMEOUT_CYCLES=255 -> o_err[winner] 255 clks after grant, busy=0, start=0.
//  Reset asserted in ACTIVE -> all outputs 0 same cycle async; after release req0 served first.
//  Change i_req_cfg of winner during ACTIVE -> o_clk_period etc. unchanged until next grant.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types and config field layout for the SPI transaction scheduler
// Purpose: FSM state encoding (one-hot, 3 bits) and the bit layout of the
//   33-bit per-requester timing config word
//   {cpol, tx2tx[7:0], hold[7:0], setup[7:0], clk_period[7:0]}.
// Ports: none (package).
package spi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_START  = 3'b010,
    ST_ACTIVE = 3'b100
  } state_t;

  localparam int CFG_W          = 33;
  localparam int CFG_FIELD_W    = 8;
  localparam int CFG_PERIOD_LSB = 0;
  localparam int CFG_SETUP_LSB  = 8;
  localparam int CFG_HOLD_LSB   = 16;
  localparam int CFG_TX2TX_LSB  = 24;
  localparam int CFG_CPOL       = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the next requester
// Purpose: returns the first set request bit strictly after i_ptr, wrapping
//   around, so the previous winner (i_ptr) has the lowest priority.
// Ports:
//   i_req     in  N        request vector
//   i_ptr     in  IW       index of the last winner
//   o_onehot  out N        one-hot winner (all zero when no request)
//   o_idx     out IW       winner index
//   o_any     out 1        at least one request present
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int k;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    k        = 0;
    // Scan ptr+1 .. ptr+N; the first hit wins, later hits are masked by o_any.
    for (int i = 1; i <= N; i++) begin
      k = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[k]) begin
        o_any       = 1'b1;
        o_idx       = IW'(k);
        o_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// rtl/spi_txn_scheduler.sv - round-robin scheduler sharing one SPI sclk/ss generator
// Purpose: arbitrates NUM_REQ level requests, latches the winner's timing
//   config and TX word, starts the generator and follows its slave-select to
//   report completion (o_done) or a start timeout (o_err) to the winner.
// Ports:
//   i_sys_clk, i_sys_rst     clock, asynchronous active-high reset
//   i_req                    level request per requester, held until o_gnt
//   i_req_data               TX word per requester, slice k = [k*DATA_SIZE +: DATA_SIZE]
//   i_req_cfg                33-bit timing config per requester, slice k = [k*33 +: 33]
//   o_gnt / o_done / o_err   one-hot single-cycle pulses for the served requester
//   o_busy                   high from grant until done/err
//   o_spi_start              start request to the generator
//   o_clk_period .. o_cpol   latched timing config to the generator
//   o_tx_data                latched TX word to the shift register
//   i_ss_start               generator slave-select, active-low
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] i_req_data,
  input  logic [NUM_REQ*CFG_W-1:0]     i_req_cfg,
  output logic [NUM_REQ-1:0]           o_gnt,
  output logic [NUM_REQ-1:0]           o_done,
  output logic [NUM_REQ-1:0]           o_err,
  output logic                         o_busy,
  output logic                         o_spi_start,
  output logic [7:0]                   o_clk_period,
  output logic [7:0]                   o_setup_cycles,
  output logic [7:0]                   o_hold_cycles,
  output logic [7:0]                   o_tx2tx_cycles,
  output logic                         o_cpol,
  output logic [DATA_SIZE-1:0]         o_tx_data,
  input  logic                         i_ss_start
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [7:0]           tmo_cnt;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [CFG_W-1:0]     win_cfg;
  logic [DATA_SIZE-1:0] win_data;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .i_req    (i_req),
    .i_ptr    (ptr),
    .o_onehot (arb_onehot),
    .o_idx    (arb_idx),
    .o_any    (arb_any)
  );

  always_comb begin
    win_cfg  = i_req_cfg[int'(arb_idx)*CFG_W +: CFG_W];
    win_data = i_req_data[int'(arb_idx)*DATA_SIZE +: DATA_SIZE];
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state          <= ST_IDLE;
      ptr            <= IW'(NUM_REQ - 1);
      tmo_cnt        <= '0;
      o_gnt          <= '0;
      o_done         <= '0;
      o_err          <= '0;
      o_busy         <= 1'b0;
      o_spi_start    <= 1'b0;
      o_clk_period   <= '0;
      o_setup_cycles <= '0;
      o_hold_cycles  <= '0;
      o_tx2tx_cycles <= '0;
      o_cpol         <= 1'b0;
      o_tx_data      <= '0;
    end else begin
      o_gnt  <= '0;
      o_done <= '0;
      o_err  <= '0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any) begin
            o_gnt          <= arb_onehot;
            ptr            <= arb_idx;
            o_clk_period   <= win_cfg[CFG_PERIOD_LSB +: CFG_FIELD_W];
            o_setup_cycles <= win_cfg[CFG_SETUP_LSB +: CFG_FIELD_W];
            o_hold_cycles  <= win_cfg[CFG_HOLD_LSB +: CFG_FIELD_W];
            o_tx2tx_cycles <= win_cfg[CFG_TX2TX_LSB +: CFG_FIELD_W];
            o_cpol         <= win_cfg[CFG_CPOL];
            o_tx_data      <= win_data;
            o_busy         <= 1'b1;
            o_spi_start    <= 1'b1;
            tmo_cnt        <= '0;
            state          <= ST_START;
          end
        end
        ST_START: begin
          // ss may still be high while the generator finishes its tx2tx gap,
          // so start stays asserted until ss actually falls.
          if (!i_ss_start) begin
            o_spi_start <= 1'b0;
            state       <= ST_ACTIVE;
          end else if (tmo_cnt == TMO_LAST) begin
            o_err       <= NUM_REQ'(1) << ptr;
            o_spi_start <= 1'b0;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (i_ss_start) begin
            o_done <= NUM_REQ'(1) << ptr;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
